multiphase_clock_divider: RTL and testbench

MULTIPHASE_CLOCK_DIVIDER -- requirements
Module: multiphase_clock_divider

---
 rtl/multiphase_clock_divider.sv | 179 +++++++++++++++++
 tb/tb_multiphase_clock_divider.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multiphase_clock_divider.sv
`default_nettype none
// ============================================================================
//  Module      : multiphase_clock_divider
//  Description : Burst-mode clock divider producing NUM_PHASES equally spaced
//                50%-duty divided clocks from clk_in. Output period is
//                P = NUM_PHASES * D, where D (div_step) is the number of clk_in
//                cycles between adjacent phases. A burst runs num_cycles
//                output periods (0 = continuous until stop).
//  Ports       : clk_in, reset_n (async, active-low)
//                div_step [DIVIDER_WIDTH], num_cycles [CYCLE_WIDTH],
//                start, stop, cpol (only with MPCD_CPOL_EN)
//                phase [NUM_PHASES], busy, done, period_tick
//  Options     : `define MPCD_CPOL_EN adds the cpol input; a latched cpol=1
//                inverts every phase bit, including the idle level.
//  Revision    : 1.0 - initial release
// ============================================================================
module multiphase_clock_divider #(
  parameter int DIVIDER_WIDTH = 8,
  parameter int NUM_PHASES    = 4,
  parameter int CYCLE_WIDTH   = 16
) (
  input  logic                     clk_in,
  input  logic                     reset_n,
  input  logic [DIVIDER_WIDTH-1:0] div_step,
  input  logic [CYCLE_WIDTH-1:0]   num_cycles,
  input  logic                     start,
  input  logic                     stop,
`ifdef MPCD_CPOL_EN
  input  logic                     cpol,
`endif
  output logic [NUM_PHASES-1:0]    phase,
  output logic                     busy,
  output logic                     done,
  output logic                     period_tick
);

  // Five extra bits hold NUM_PHASES*D (up to 16*max D) plus one extra
  // period used by the modulo-free phase offset arithmetic below.
  localparam int                 CNT_W     = DIVIDER_WIDTH + 5;
  localparam logic [CNT_W-1:0]   C_NP      = CNT_W'(NUM_PHASES);
  localparam logic [CNT_W-1:0]   C_HALF_NP = CNT_W'(NUM_PHASES / 2);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [CNT_W-1:0]         r_counter, w_counter_nxt;
  logic [CYCLE_WIDTH-1:0]   r_period_cnt, w_period_cnt_nxt;
  logic [DIVIDER_WIDTH-1:0] r_d_l;
  logic [CYCLE_WIDTH-1:0]   r_n_l;
  logic                     r_stop_pend, w_stop_pend_nxt;
  logic                     r_done, w_done_nxt;
  logic [NUM_PHASES-1:0]    r_phase, w_phase_nxt;
  logic                     w_load;
  logic                     w_run_nxt;
  logic                     w_cpol_eff;
  logic [DIVIDER_WIDTH-1:0] w_d_eff;
  logic [CNT_W-1:0]         w_p;
  logic [CNT_W-1:0]         w_p_eff;
  logic [CNT_W-1:0]         w_half_eff;
  logic                     w_last_period;

  assign w_p           = C_NP * {5'b0, r_d_l};
  assign w_last_period = (r_n_l != '0) && (r_period_cnt == r_n_l - CYCLE_WIDTH'(1));

  // --------------------------------------------------------------------------
  // Next-state and datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_counter_nxt    = r_counter;
    w_period_cnt_nxt = r_period_cnt;
    w_stop_pend_nxt  = r_stop_pend;
    w_done_nxt       = 1'b0;
    w_load           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && (div_step != '0)) begin
          w_state_nxt      = ST_RUN;
          w_load           = 1'b1;
          w_counter_nxt    = '0;
          w_period_cnt_nxt = '0;
          w_stop_pend_nxt  = 1'b0;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_stop_pend_nxt = 1'b1;
        end
        if (r_counter == w_p - CNT_W'(1)) begin
          w_counter_nxt = '0;
          // A stop arriving on the wrap cycle itself ends this period; a
          // last-period wrap with stop pending is still one end event.
          if (r_stop_pend || stop || w_last_period) begin
            w_state_nxt     = ST_IDLE;
            w_done_nxt      = 1'b1;
            w_stop_pend_nxt = 1'b0;
          end else if (!(&r_period_cnt)) begin
            w_period_cnt_nxt = r_period_cnt + CYCLE_WIDTH'(1);
          end
        end else begin
          w_counter_nxt = r_counter + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Phase generation: each bit is computed from the counter value it will be
  // presented with, so the registered output lines up with that cycle.
  // --------------------------------------------------------------------------
  assign w_run_nxt  = (w_state_nxt == ST_RUN);
  assign w_d_eff    = w_load ? div_step : r_d_l;
  assign w_p_eff    = C_NP * {5'b0, w_d_eff};
  assign w_half_eff = C_HALF_NP * {5'b0, w_d_eff};

`ifdef MPCD_CPOL_EN
  logic r_cpol_l;
  assign w_cpol_eff = w_load ? cpol : r_cpol_l;
`else
  assign w_cpol_eff = 1'b0;
`endif

  for (genvar k = 0; k < NUM_PHASES; k++) begin : g_phase
    logic [CNT_W-1:0] w_kd;
    logic [CNT_W-1:0] w_sum;
    logic [CNT_W-1:0] w_off;
    // (counter - k*D) mod P, using one conditional subtract: k*D < P always.
    assign w_kd  = CNT_W'(k) * {5'b0, w_d_eff};
    assign w_sum = w_counter_nxt + w_p_eff - w_kd;
    assign w_off = (w_sum >= w_p_eff) ? (w_sum - w_p_eff) : w_sum;
    assign w_phase_nxt[k] = (w_run_nxt && (w_off < w_half_eff)) ^ w_cpol_eff;
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_counter    <= '0;
      r_period_cnt <= '0;
      r_d_l        <= '0;
      r_n_l        <= '0;
      r_stop_pend  <= 1'b0;
      r_done       <= 1'b0;
      r_phase      <= '0;
`ifdef MPCD_CPOL_EN
      r_cpol_l     <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_counter    <= w_counter_nxt;
      r_period_cnt <= w_period_cnt_nxt;
      r_stop_pend  <= w_stop_pend_nxt;
      r_done       <= w_done_nxt;
      r_phase      <= w_phase_nxt;
      if (w_load) begin
        r_d_l <= div_step;
        r_n_l <= num_cycles;
`ifdef MPCD_CPOL_EN
        r_cpol_l <= cpol;
`endif
      end
    end
  end

  assign phase       = r_phase;
  assign busy        = (r_state == ST_RUN);
  assign done        = r_done;
  assign period_tick = (r_state == ST_RUN) && (r_counter == '0);

endmodule
`default_nettype wire

// File: tb/tb_multiphase_clock_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multiphase_clock_divider
//  Description : Self-checking bench for multiphase_clock_divider. A burst
//                model tracks elapsed RUN cycles t; every output follows from
//                t mod P and t / P. Directed bursts pin the model with literal
//                expectations, then randomized start/stop/reset traffic runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multiphase_clock_divider;

  localparam int DW = 8;
  localparam int NP = 4;
  localparam int CW = 16;

  logic          clk_in = 1'b0;
  logic          reset_n;
  logic [DW-1:0] div_step;
  logic [CW-1:0] num_cycles;
  logic          start;
  logic          stop;
  logic          cpol;
  logic [NP-1:0] phase;
  logic          busy;
  logic          done;
  logic          period_tick;

  multiphase_clock_divider #(
    .DIVIDER_WIDTH(DW),
    .NUM_PHASES   (NP),
    .CYCLE_WIDTH  (CW)
  ) dut (
    .clk_in     (clk_in),
    .reset_n    (reset_n),
    .div_step   (div_step),
    .num_cycles (num_cycles),
    .start      (start),
    .stop       (stop),
`ifdef MPCD_CPOL_EN
    .cpol       (cpol),
`endif
    .phase      (phase),
    .busy       (busy),
    .done       (done),
    .period_tick(period_tick)
  );

  always #5 clk_in = ~clk_in;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Burst model: m_t counts RUN cycles since the accepted start.
  // --------------------------------------------------------------------------
  bit m_run  = 1'b0;
  bit m_done = 1'b0;
  bit m_stop = 1'b0;
  bit m_cpol = 1'b0;
  int m_t    = 0;
  int m_d    = 0;
  int m_n    = 0;

  always @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      m_run  <= 1'b0;
      m_done <= 1'b0;
      m_stop <= 1'b0;
      m_cpol <= 1'b0;
      m_t    <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_run) begin
        if (stop) m_stop <= 1'b1;
        if ((m_t % (NP * m_d)) == (NP * m_d - 1) &&
            (m_stop || stop || (m_n != 0 && (m_t / (NP * m_d)) + 1 == m_n))) begin
          m_run  <= 1'b0;
          m_done <= 1'b1;
          m_stop <= 1'b0;
        end else begin
          m_t <= m_t + 1;
        end
      end else if (start && div_step != 0) begin
        m_run  <= 1'b1;
        m_t    <= 0;
        m_d    <= int'(div_step);
        m_n    <= int'(num_cycles);
        m_stop <= 1'b0;
`ifdef MPCD_CPOL_EN
        m_cpol <= cpol;
`endif
      end
    end
  end

  function automatic logic [NP-1:0] exp_phase(input bit run, input int t, input int d, input bit cp);
    logic [NP-1:0] r;
    int p;
    r = '0;
    if (run) begin
      p = NP * d;
      for (int k = 0; k < NP; k++) begin
        r[k] = ((((t % p) - k * d + p) % p) < (p / 2));
      end
    end
    return cp ? ~r : r;
  endfunction

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk_in) begin
    check("phase", 32'(phase), 32'(exp_phase(m_run, m_t, m_d, m_cpol)));
    check("busy", 32'(busy), 32'(m_run));
    check("period_tick", 32'(period_tick), 32'(m_run && ((m_t % (NP * m_d)) == 0)));
    check("done", 32'(done), 32'(m_done));
  end

  // Observe n cycles from the current negedge; capture phase at offsets 0 and 2.
  task automatic measure(input int n, output int nb, output int nt, output int nd,
                         output logic [NP-1:0] p0, output logic [NP-1:0] p2);
    nb = 0; nt = 0; nd = 0; p0 = '0; p2 = '0;
    for (int i = 0; i < n; i++) begin
      if (i == 0) p0 = phase;
      if (i == 2) p2 = phase;
      if (busy) nb++;
      if (period_tick) nt++;
      if (done) nd++;
      @(negedge clk_in);
    end
  endtask

  task automatic pulse_start(input int d, input int n);
    div_step   = DW'(d);
    num_cycles = CW'(n);
    start      = 1'b1;
    @(negedge clk_in);
    start      = 1'b0;
  endtask

  int            nb, nt, nd;
  logic [NP-1:0] p0, p2;

  initial begin
    reset_n    = 1'b0;
    div_step   = '0;
    num_cycles = '0;
    start      = 1'b0;
    stop       = 1'b0;
    cpol       = 1'b0;
    repeat (3) @(negedge clk_in);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_phase", 32'(phase), 32'd0);
    reset_n = 1'b1;
    @(negedge clk_in);

    // Finite burst: D=2, 3 periods of 8.
    pulse_start(2, 3);
    measure(40, nb, nt, nd, p0, p2);
    check("burst_phase_t0", 32'(p0), 32'b1001);
    check("burst_phase_t2", 32'(p2), 32'b0011);
    check("burst_busy_cycles", nb, 24);
    check("burst_ticks", nt, 3);
    check("burst_done_pulses", nd, 1);

    // D=0 start is ignored.
    pulse_start(0, 3);
    measure(6, nb, nt, nd, p0, p2);
    check("d0_busy_cycles", nb, 0);
    check("d0_done_pulses", nd, 0);

    // Continuous, D=3, stop from counter 5: finishes at counter 11.
    pulse_start(3, 0);
    repeat (5) @(negedge clk_in);
    stop = 1'b1;
    measure(12, nb, nt, nd, p0, p2);
    stop = 1'b0;
    check("stop_busy_cycles", nb, 7);
    check("stop_done_pulses", nd, 1);
    check("stop_idle_phase", 32'(phase), 32'd0);

    // div_step change mid-burst has no effect until the next start.
    pulse_start(2, 2);
    repeat (3) @(negedge clk_in);
    div_step = 8'd5;
    measure(30, nb, nt, nd, p0, p2);
    check("chg_busy_remaining", nb, 13);
    pulse_start(5, 1);
    measure(30, nb, nt, nd, p0, p2);
    check("chg_next_busy", nb, 20);
    check("chg_next_ticks", nt, 1);

    // Async reset at counter 3 of the second period.
    pulse_start(2, 4);
    repeat (11) @(negedge clk_in);
    #2 reset_n = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_phase", 32'(phase), 32'd0);
    check("async_tick", 32'(period_tick), 32'd0);
    @(negedge clk_in);
    reset_n = 1'b1;
    measure(5, nb, nt, nd, p0, p2);
    check("post_reset_idle", nb, 0);
    pulse_start(2, 4);
    measure(40, nb, nt, nd, p0, p2);
    check("post_reset_phase_t0", 32'(p0), 32'b1001);
    check("post_reset_busy", nb, 32);

`ifdef MPCD_CPOL_EN
    cpol = 1'b1;
    pulse_start(1, 1);
    check("cpol_t0_p0", 32'(phase[0]), 32'd0);
    measure(8, nb, nt, nd, p0, p2);
    check("cpol_t2_p0", 32'(p2[0]), 32'd1);
    check("cpol_busy", nb, 4);
    check("cpol_idle", 32'(phase), 32'hF);
    cpol = 1'b0;
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom % 6) == 0;
      stop  = ($urandom % 30) == 0;
      if (($urandom % 10) == 0) div_step = DW'($urandom % 5);
      num_cycles = CW'($urandom % 4);
      cpol       = 1'($urandom % 2);
      if (($urandom % 700) == 0) begin
        #2 reset_n = 1'b0;
        #1 reset_n = 1'b1;
      end
      @(negedge clk_in);
    end
    start = 1'b0;
    stop  = 1'b0;
    repeat (2) @(negedge clk_in);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
